// File: rtl/stopwatch_ctrl_if.sv
// Button levels into and display/status values out of the stopwatch controller.
// Buttons are plain debounced levels (no valid/ready); outputs are continuously valid registered-state decodes.
interface stopwatch_ctrl_if #(
    parameter int MIN_WIDTH = 7
);
    logic                 i_run_stop;
    logic                 i_clear;
    logic                 i_lap;
    logic                 o_run;
    logic                 o_stop;
    logic                 o_clear;
    logic                 o_lap;
    logic [6:0]           o_csec;
    logic [5:0]           o_sec;
    logic [MIN_WIDTH-1:0] o_min;
    logic                 o_tick;
    logic                 o_wrap;
    logic [1:0]           o_state;

    modport master (
        output i_run_stop, i_clear, i_lap,
        input  o_run, o_stop, o_clear, o_lap, o_csec, o_sec, o_min, o_tick, o_wrap, o_state
    );

    modport slave (
        input  i_run_stop, i_clear, i_lap,
        output o_run, o_stop, o_clear, o_lap, o_csec, o_sec, o_min, o_tick, o_wrap, o_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, STOP/RUN/CLEAR/LAP FSM,
// centisecond time base, min:sec:csec counter and lap freeze for the display mux.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MIN_WIDTH = 7,
    parameter int MIN_MAX   = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    stopwatch_ctrl_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]        PRESC_LAST = PW'(DIV - 1);
    localparam logic [MIN_WIDTH-1:0] MIN_LAST   = MIN_WIDTH'(MIN_MAX);

    localparam logic [1:0] S_STOP  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_prev_rs, r_prev_cl, r_prev_lp;
    logic                 r_ev_rs, r_ev_cl, r_ev_lp;
    logic [PW-1:0]        r_presc;
    logic [6:0]           r_csec;
    logic [5:0]           r_sec;
    logic [MIN_WIDTH-1:0] r_min;
    logic [6:0]           r_lap_csec;
    logic [5:0]           r_lap_sec;
    logic [MIN_WIDTH-1:0] r_lap_min;
    logic                 w_counting;
    logic                 w_clr;
    logic                 w_tick;
    logic                 w_csec_last, w_sec_last, w_min_last;
    logic                 w_wrap;
    logic                 w_lap_load;

    // History resets to 1 so a button held through reset produces no event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_rs <= 1'b1;
            r_prev_cl <= 1'b1;
            r_prev_lp <= 1'b1;
            r_ev_rs   <= 1'b0;
            r_ev_cl   <= 1'b0;
            r_ev_lp   <= 1'b0;
        end else begin
            r_prev_rs <= bus.i_run_stop;
            r_prev_cl <= bus.i_clear;
            r_prev_lp <= bus.i_lap;
            r_ev_rs   <= bus.i_run_stop & ~r_prev_rs;
            r_ev_cl   <= bus.i_clear    & ~r_prev_cl;
            r_ev_lp   <= bus.i_lap      & ~r_prev_lp;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_STOP:  if (r_ev_rs) w_next_state = S_RUN;
                     else if (r_ev_cl) w_next_state = S_CLEAR;
            S_RUN:   if (r_ev_rs) w_next_state = S_STOP;
                     else if (r_ev_lp) w_next_state = S_LAP;
            S_LAP:   if (r_ev_rs) w_next_state = S_STOP;
                     else if (r_ev_lp) w_next_state = S_RUN;
            S_CLEAR: if (r_ev_rs) w_next_state = S_RUN;
            default: w_next_state = S_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_STOP;
        else          r_state <= w_next_state;
    end

    assign w_counting  = (r_state == S_RUN) || (r_state == S_LAP);
    // Clearing also on entry keeps the display at zero in the first CLEAR cycle.
    assign w_clr       = (r_state == S_CLEAR) || (w_next_state == S_CLEAR);
    assign w_tick      = w_counting && (r_presc == PRESC_LAST);
    assign w_csec_last = (r_csec == 7'd99);
    assign w_sec_last  = (r_sec == 6'd59);
    assign w_min_last  = (r_min == MIN_LAST);
    assign w_wrap      = w_tick && w_csec_last && w_sec_last && w_min_last;
    assign w_lap_load  = (r_state == S_RUN) && (w_next_state == S_LAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_presc <= '0;
        else if (w_clr)      r_presc <= '0;
        else if (w_tick)     r_presc <= '0;
        else if (w_counting) r_presc <= r_presc + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
        end else if (w_clr) begin
            r_csec <= '0;
            r_sec  <= '0;
            r_min  <= '0;
        end else if (w_tick) begin
            if (w_csec_last) begin
                r_csec <= '0;
                if (w_sec_last) begin
                    r_sec <= '0;
                    r_min <= w_min_last ? '0 : r_min + MIN_WIDTH'(1);
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else begin
                r_csec <= r_csec + 7'd1;
            end
        end
    end

    // Lap captures the pre-edge count, so a tick on the same edge is excluded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lap_csec <= '0;
            r_lap_sec  <= '0;
            r_lap_min  <= '0;
        end else if (w_clr) begin
            r_lap_csec <= '0;
            r_lap_sec  <= '0;
            r_lap_min  <= '0;
        end else if (w_lap_load) begin
            r_lap_csec <= r_csec;
            r_lap_sec  <= r_sec;
            r_lap_min  <= r_min;
        end
    end

    assign bus.o_run   = w_counting;
    assign bus.o_stop  = (r_state == S_STOP);
    assign bus.o_clear = (r_state == S_CLEAR);
    assign bus.o_lap   = (r_state == S_LAP);
    assign bus.o_csec  = (r_state == S_LAP) ? r_lap_csec : r_csec;
    assign bus.o_sec   = (r_state == S_LAP) ? r_lap_sec  : r_sec;
    assign bus.o_min   = (r_state == S_LAP) ? r_lap_min  : r_min;
    assign bus.o_tick  = w_tick;
    assign bus.o_wrap  = w_wrap;
    assign bus.o_state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: main instance at DIV=10, second instance at DIV=2 for the full wrap.
module tb_stopwatch_ctrl;
  logic clk;
  logic reset_n;

  stopwatch_ctrl_if #(.MIN_WIDTH(2)) b1 ();
  stopwatch_ctrl_if #(.MIN_WIDTH(2)) b2 ();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_WIDTH(2), .MIN_MAX(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave)
  );

  stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100), .MIN_WIDTH(2), .MIN_MAX(1)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave)
  );

  localparam logic [3:0] ST_STOP = 4'b1000;
  localparam logic [3:0] ST_RUN  = 4'b0100;
  localparam logic [3:0] ST_CLR  = 4'b0010;
  localparam logic [3:0] ST_LAP  = 4'b0101;

  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int tick1 = 0;
  int wrap1 = 0;
  int wrap2 = 0;
  logic found;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b1.o_tick === 1'b1) tick1++;
    if (b1.o_wrap === 1'b1) wrap1++;
    if (b2.o_wrap === 1'b1) wrap2++;
  end

  function automatic logic [31:0] mk(input logic [3:0] st, input int m, input int s, input int c);
    return {13'd0, st, m[1:0], s[5:0], c[6:0]};
  endfunction

  function automatic logic [31:0] disp1();
    return {13'd0, b1.o_stop, b1.o_run, b1.o_clear, b1.o_lap, b1.o_min, b1.o_sec, b1.o_csec};
  endfunction

  function automatic logic [31:0] disp2();
    return {13'd0, b2.o_stop, b2.o_run, b2.o_clear, b2.o_lap, b2.o_min, b2.o_sec, b2.o_csec};
  endfunction

  // scoreboard
  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // driver tasks; called at a negedge, return two negedges later with the new state visible
  task automatic pulse1(input logic rs, input logic cl, input logic lp);
    b1.i_run_stop = rs;
    b1.i_clear    = cl;
    b1.i_lap      = lp;
    @(negedge clk);
    b1.i_run_stop = 1'b0;
    b1.i_clear    = 1'b0;
    b1.i_lap      = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse2_run();
    b2.i_run_stop = 1'b1;
    @(negedge clk);
    b2.i_run_stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    b1.i_run_stop = 1'b1;
    b1.i_clear = 1'b0;
    b1.i_lap = 1'b0;
    b2.i_run_stop = 1'b0;
    b2.i_clear = 1'b0;
    b2.i_lap = 1'b0;
    found = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: run_stop held through reset gives no event
    push(mk(ST_STOP, 0, 0, 0));
    repeat (50) @(negedge clk);
    chk("t1_held_rs", disp1());
    #1;
    push(32'd0);
    chk("t1_no_tick", 32'(tick1));
    b1.i_run_stop = 1'b0;
    @(negedge clk);

    // 2: run for 250 cycles then stop
    push(mk(ST_RUN, 0, 0, 0));
    pulse1(1'b1, 1'b0, 1'b0);
    chk("t2_run", disp1());
    repeat (248) @(negedge clk);
    push(mk(ST_STOP, 0, 0, 25));
    pulse1(1'b1, 1'b0, 1'b0);
    chk("t2_stop_25", disp1());
    #1;
    push(32'd25);
    chk("t2_tick_count", 32'(tick1));
    push(mk(ST_STOP, 0, 0, 25));
    repeat (100) @(negedge clk);
    chk("t2_frozen", disp1());
    #1;
    push(32'd25);
    chk("t2_no_tick_stopped", 32'(tick1));

    // 4: lap ignored in STOP, clear, lap ignored in CLEAR, clear+run_stop -> RUN
    @(negedge clk);
    push(mk(ST_STOP, 0, 0, 25));
    pulse1(1'b0, 1'b0, 1'b1);
    chk("t4_lap_ign_stop", disp1());
    push(mk(ST_CLR, 0, 0, 0));
    pulse1(1'b0, 1'b1, 1'b0);
    chk("t4_clear", disp1());
    push(mk(ST_CLR, 0, 0, 0));
    pulse1(1'b0, 1'b0, 1'b1);
    chk("t4_lap_ign_clear", disp1());
    push(mk(ST_RUN, 0, 0, 0));
    pulse1(1'b1, 1'b1, 1'b0);
    chk("t4_rs_priority", disp1());
    push(mk(ST_RUN, 0, 0, 10));
    repeat (100) @(negedge clk);
    chk("t4_restart_from_0", disp1());

    // 3: lap on the edge of the 13th increment freezes 12; release shows live count
    repeat (28) @(negedge clk);
    push(mk(ST_LAP, 0, 0, 12));
    pulse1(1'b0, 1'b0, 1'b1);
    chk("t3_lap_freeze", disp1());
    push(mk(ST_LAP, 0, 0, 12));
    repeat (100) @(negedge clk);
    chk("t3_lap_hold", disp1());
    push(mk(ST_RUN, 0, 0, 23));
    pulse1(1'b0, 1'b0, 1'b1);
    chk("t3_lap_release", disp1());

    // 5: full wrap on the DIV=2 instance
    push(mk(ST_RUN, 0, 0, 0));
    pulse2_run();
    chk("t5_run", disp2());
    push(mk(ST_RUN, 0, 1, 0));
    repeat (200) @(negedge clk);
    chk("t5_sec_carry", disp2());
    push(mk(ST_RUN, 1, 0, 0));
    repeat (11800) @(negedge clk);
    chk("t5_min_carry", disp2());
    push(mk(ST_RUN, 1, 59, 99));
    repeat (11998) @(negedge clk);
    chk("t5_last_value", disp2());
    #1;
    push(32'd0);
    chk("t5_no_early_wrap", 32'(wrap2));
    @(negedge clk);
    push(32'd3);
    chk("t5_tick_wrap", {30'd0, b2.o_tick, b2.o_wrap});
    @(negedge clk);
    push(mk(ST_RUN, 0, 0, 0));
    chk("t5_wrapped", disp2());
    push(32'd0);
    chk("t5_pulse_end", {30'd0, b2.o_tick, b2.o_wrap});
    #1;
    push(32'd1);
    chk("t5_wrap_once", 32'(wrap2));

    // 6: reset asserted in a tick cycle
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (b1.o_tick === 1'b1) found = 1'b1;
    end
    push(32'd1);
    chk("t6_tick_seen", {31'd0, found});
    #2;
    reset_n = 1'b0;
    #1;
    push(mk(ST_STOP, 0, 0, 0));
    chk("t6_async_reset", disp1());
    push(32'd0);
    chk("t6_no_pulse", {30'd0, b1.o_tick, b1.o_wrap});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    push(mk(ST_STOP, 0, 0, 0));
    chk("t6_after_release", disp1());
    #1;
    push(32'd0);
    chk("t6_no_wrap_main", 32'(wrap1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
